video_timing_monitor: RTL

Passive monitor on the HDMI-clock output stream, sitting directly downstream of `ram2video` alongside the ADV7513 transmitter. It watches `HSYNC`, `VSYNC`, `DE` and the 24-bit video bus and measures the delivered timing each frame: total and active pixels per line, and total and active lines per frame. It flags mode stability and DE-width inconsistency, and optionally computes a per-frame pixel signature. Results feed `debugData` for readout over the ESP I2C path.

---
 rtl/video_timing_monitor_pkg.sv | 30 +++
 rtl/video_timing_monitor_if.sv | 32 +++
 rtl/video_timing_monitor_frame_signature.sv | 29 ++
 rtl/video_timing_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_monitor_pkg.sv
// Shared types for the video timing monitor: state encoding, debug readout record, signature step.
// Signature logic is used only when VIDEO_TIMING_MONITOR_SIGNATURE_EN is defined.
package video_timing_monitor_pkg;

    localparam int unsigned TM_CNT_W = 12;
    localparam int unsigned SIG_W    = 16;
    localparam int unsigned FC_W     = 16;

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic [TM_CNT_W-1:0] h_total;
        logic [TM_CNT_W-1:0] h_active;
        logic [TM_CNT_W-1:0] v_total;
        logic [TM_CNT_W-1:0] v_active;
        logic [FC_W-1:0]     frame_count;
        logic                stable;
        logic                de_error;
        logic [SIG_W-1:0]    signature;
    } TimingMeasurement;

    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] s,
                                                  input logic [23:0]      px);
        return {s[SIG_W-2:0], s[SIG_W-1]} ^ px[15:0] ^ {8'h00, px[23:16]};
    endfunction

endpackage

// File: rtl/video_timing_monitor_if.sv
// Video stream taps and measurement results of the timing monitor.
// master = stream source / result reader, slave = monitor.
interface video_timing_monitor_if #(
    parameter int CNT_W = 12
);
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [23:0]      video;
    logic             clear;
    logic             meas_valid;
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_active;
    logic [15:0]      frame_count;
    logic             stable;
    logic             de_error;
    logic [15:0]      signature;

    modport master (
        output hsync, vsync, de, video, clear,
        input  meas_valid, h_total, h_active, v_total, v_active,
               frame_count, stable, de_error, signature
    );

    modport slave (
        input  hsync, vsync, de, video, clear,
        output meas_valid, h_total, h_active, v_total, v_active,
               frame_count, stable, de_error, signature
    );
endinterface

// File: rtl/video_timing_monitor_frame_signature.sv
// Per-frame rotating XOR signature over DE pixels; restarts at each frame boundary.
// Built only when VIDEO_TIMING_MONITOR_SIGNATURE_EN is defined.
`ifdef VIDEO_TIMING_MONITOR_SIGNATURE_EN
module frame_signature
    import video_timing_monitor_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             pixel_en_i,
    input  logic             restart_i,
    input  logic [23:0]      pixel_i,
    output logic [SIG_W-1:0] sig_o
);
    logic [SIG_W-1:0] sig_q, sig_d;

    // A pixel on the boundary cycle belongs to the frame that is starting.
    always_comb begin
        sig_d = restart_i ? '0 : sig_q;
        if (pixel_en_i) sig_d = sig_step(sig_d, pixel_i);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sig_q <= '0;
        else       sig_q <= sig_d;
    end

    assign sig_o = sig_q;
endmodule
`endif

// File: rtl/video_timing_monitor.sv
// Passive per-frame timing measurement of the HDMI output stream (line/frame totals, DE extents, stability).
// Optional pixel signature under VIDEO_TIMING_MONITOR_SIGNATURE_EN; otherwise signature reads 0.
module video_timing_monitor
    import video_timing_monitor_pkg::*;
#(
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int STABLE_FRAMES    = 4,
    parameter int CNT_W            = 12
) (
    input logic                   clock,
    input logic                   reset,
    video_timing_monitor_if.slave bus
);
    localparam int MC_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [MC_W-1:0]  MC_FULL = MC_W'(STABLE_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic hs_in, vs_in;
    logic hs_q, vs_q, de_q, hs_prev_q, vs_prev_q, de_prev_q;
    logic hs_lead, vs_lead, de_fall;

    mon_state_e state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, line_len_q, line_len_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] de_cnt_q, de_cnt_d, ref_w_q, ref_w_d, v_act_q, v_act_d;
    logic             ref_seen_q, ref_seen_d, frame_err_q, frame_err_d;

    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
    logic [CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic             stable_q, stable_d, de_error_q, de_error_d;
    logic [15:0]      signature_q, signature_d, sig;

    assign hs_in   = (SYNC_ACTIVE_HIGH != 0) ? bus.hsync : ~bus.hsync;
    assign vs_in   = (SYNC_ACTIVE_HIGH != 0) ? bus.vsync : ~bus.vsync;
    assign hs_lead = hs_q & ~hs_prev_q;
    assign vs_lead = vs_q & ~vs_prev_q;
    assign de_fall = ~de_q & de_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {hs_q, vs_q, de_q, hs_prev_q, vs_prev_q, de_prev_q} <= '0;
        end else begin
            hs_q      <= hs_in;
            vs_q      <= vs_in;
            de_q      <= bus.de;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            de_prev_q <= de_q;
        end
    end

`ifdef VIDEO_TIMING_MONITOR_SIGNATURE_EN
    logic [23:0] video_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) video_q <= '0;
        else       video_q <= bus.video;
    end

    frame_signature u_frame_signature (
        .clock      (clock),
        .reset      (reset),
        .pixel_en_i (de_q),
        .restart_i  (vs_lead),
        .pixel_i    (video_q),
        .sig_o      (sig)
    );
`else
    logic unused_video;
    assign unused_video = ^bus.video;
    assign sig          = '0;
`endif

    always_comb begin
        state_d    = state_q;
        h_cnt_d    = hs_lead ? '0 : sat_inc(h_cnt_q);
        line_len_d = hs_lead ? sat_inc(h_cnt_q) : line_len_q;
        v_cnt_d    = hs_lead ? sat_inc(v_cnt_q) : v_cnt_q;
        de_cnt_d   = de_q ? sat_inc(de_cnt_q) : '0;

        v_act_d     = v_act_q;
        ref_w_d     = ref_w_q;
        ref_seen_d  = ref_seen_q;
        frame_err_d = frame_err_q;
        if (de_fall) begin
            v_act_d = sat_inc(v_act_q);
            if (!ref_seen_q) begin
                ref_w_d    = de_cnt_q;
                ref_seen_d = 1'b1;
            end else if (de_cnt_q != ref_w_q) begin
                frame_err_d = 1'b1;
            end
        end

        meas_valid_d  = 1'b0;
        h_total_d     = h_total_q;
        h_active_d    = h_active_q;
        v_total_d     = v_total_q;
        v_active_d    = v_active_q;
        signature_d   = signature_q;
        match_cnt_d   = match_cnt_q;
        stable_d      = stable_q;
        frame_count_d = bus.clear ? '0 : frame_count_q;
        de_error_d    = de_error_q & ~bus.clear;

        // Line and DE events coincident with the boundary close the ending frame
        // (the _d values), while a coincident hsync lead also opens line 1 of the new one.
        if (vs_lead) begin
            if (state_q == MEASURE) begin
                meas_valid_d  = 1'b1;
                h_total_d     = line_len_d;
                h_active_d    = ref_w_d;
                v_total_d     = v_cnt_q;
                v_active_d    = v_act_d;
                signature_d   = sig;
                frame_count_d = frame_count_d + 16'd1;
                if (frame_err_d) de_error_d = 1'b1;
                if ({line_len_d, ref_w_d, v_cnt_q, v_act_d} ==
                    {h_total_q, h_active_q, v_total_q, v_active_q})
                    match_cnt_d = (match_cnt_q == MC_FULL) ? MC_FULL : match_cnt_q + MC_W'(1);
                else
                    match_cnt_d = '0;
                stable_d = (match_cnt_d == MC_FULL);
            end
            state_d     = MEASURE;
            v_cnt_d     = hs_lead ? CNT_W'(1) : '0;
            v_act_d     = '0;
            ref_w_d     = '0;
            ref_seen_d  = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= SEEK;
            h_cnt_q       <= '0;
            line_len_q    <= '0;
            v_cnt_q       <= '0;
            de_cnt_q      <= '0;
            ref_w_q       <= '0;
            v_act_q       <= '0;
            ref_seen_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            meas_valid_q  <= 1'b0;
            h_total_q     <= '0;
            h_active_q    <= '0;
            v_total_q     <= '0;
            v_active_q    <= '0;
            frame_count_q <= '0;
            match_cnt_q   <= '0;
            stable_q      <= 1'b0;
            de_error_q    <= 1'b0;
            signature_q   <= '0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            line_len_q    <= line_len_d;
            v_cnt_q       <= v_cnt_d;
            de_cnt_q      <= de_cnt_d;
            ref_w_q       <= ref_w_d;
            v_act_q       <= v_act_d;
            ref_seen_q    <= ref_seen_d;
            frame_err_q   <= frame_err_d;
            meas_valid_q  <= meas_valid_d;
            h_total_q     <= h_total_d;
            h_active_q    <= h_active_d;
            v_total_q     <= v_total_d;
            v_active_q    <= v_active_d;
            frame_count_q <= frame_count_d;
            match_cnt_q   <= match_cnt_d;
            stable_q      <= stable_d;
            de_error_q    <= de_error_d;
            signature_q   <= signature_d;
        end
    end

    assign bus.meas_valid  = meas_valid_q;
    assign bus.h_total     = h_total_q;
    assign bus.h_active    = h_active_q;
    assign bus.v_total     = v_total_q;
    assign bus.v_active    = v_active_q;
    assign bus.frame_count = frame_count_q;
    assign bus.stable      = stable_q;
    assign bus.de_error    = de_error_q;
    assign bus.signature   = signature_q;

endmodule
